mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Shares one single-port memory between four requesters: 13-bit address, 8-bit data.
- Arbitrates round-robin and sequences each access through a fixed-latency memory transaction.
- Returns read data and a one-cycle acknowledge to the winning requester.
- Sits between the CPU-side clients (fetch, load/store, DMA, debug) and the memory. It drives the address/data steering selects that the 13-bit, 8-bit and 4:1 muxes consume.

Parameters:
- N_REQ, 4, number of requesters; fixed at 4, matching the 2-bit select width.
- ADDR_W, 13, address width.
- DATA_W, 8, data width.
- MEM_LAT, 2, cycles from the mem_en cycle to valid mem_rdata; legal range is 1..7.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- req  in  N_REQ  per-requester request level.
- we  in  N_REQ  per-requester write enable; 1 = write.
- addr  in  N_REQ*ADDR_W  flattened addresses; requester i occupies bits [i*ADDR_W +: ADDR_W].
- wdata  in  N_REQ*DATA_W  flattened write data, same packing as addr.
- ack  out  N_REQ  one-hot, single-cycle completion pulse.
- rdata  out  DATA_W  read data; valid while ack is high.
- gnt_id  out  2  index of the current or last granted requester (mux select).
- busy  out  1  high whenever the state is not IDLE.
- mem_en  out  1  memory access strobe.
- mem_we  out  1  memory write enable.
- mem_addr  out  ADDR_W  memory address.
- mem_wdata  out  DATA_W  memory write data.
- mem_rdata  in  DATA_W  memory read data.

Behaviour:
- Reset (asynchronous, rst_n=0):
  - state=IDLE; ack, rdata, gnt_id, busy, mem_en, mem_we, mem_addr and mem_wdata all 0.
  - Round-robin pointer ptr=3, so requester 0 has first priority.
- Reset mid-transaction aborts immediately: no ack is issued and mem_en drops asynchronously.
- FSM states: IDLE -> ISSUE -> WAIT -> RESP -> IDLE.
- IDLE: if any req bit is high:
  - Pick the first set bit searching ptr+1, ptr+2, ptr+3, ptr (mod 4).
  - Register gnt_id, and latch that requester's we, addr and wdata into mem_we, mem_addr and mem_wdata.
  - Go to ISSUE.
  - Otherwise stay in IDLE.
- ISSUE: mem_en=1 for exactly one cycle. Load the latency counter with MEM_LAT-1. Go to WAIT.
- WAIT: lasts exactly MEM_LAT cycles, counting down.
  - On the final WAIT cycle (counter==0), register mem_rdata into rdata, for both reads and writes.
  - Go to RESP.
- RESP: ack[gnt_id]=1 for one cycle, then set ptr=gnt_id and go to IDLE.
- Timing:
  - A request sampled in IDLE at cycle 0 produces mem_en in cycle 1 and ack in cycle MEM_LAT+2.
  - Minimum service period is MEM_LAT+3 cycles.
- Requester rule:
  - Hold req, we, addr and wdata stable until ack is seen.
  - Drop req at the clock edge that ends the ack cycle.
  - req still high in the following IDLE cycle counts as a new request.
- Inputs are sampled only in IDLE; changes to req, we, addr or wdata during ISSUE/WAIT/RESP are ignored.
- mem_addr, mem_we and mem_wdata hold their latched values until the next grant.
- gnt_id holds its value after RESP.
- Simultaneous requests: exactly one grant per IDLE pass. No requester waits more than 3 other services.
- rdata holds its last value outside RESP.

Decomposition:
- Package mem_arb_pkg:
  - constants N_REQ, ADDR_W, DATA_W, ID_W=2;
  - typedef enum logic[1:0] {IDLE, ISSUE, WAIT, RESP} arb_state_t;
  - typedefs addr_t and data_t.
- Sub-module rr_picker: combinational.
  - Inputs: 4-bit req and 2-bit ptr.
  - Outputs: any_req and 2-bit winner.
  - Verified standalone with an exhaustive 64-case check.

Test Plan:
1. Single read: after reset, req[1]=1, addr1=0x0A5, we1=0; memory model returns 0x3C, MEM_LAT=2 -> mem_en=1 and mem_addr=0x0A5 in cycle 1; ack=4'b0010 and rdata=0x3C in cycle 4; busy low from cycle 5.
2. Single write: req[2], addr2=0x1FFF, wdata2=0xA5, we2=1 -> cycle 1 shows mem_en=1, mem_we=1, mem_addr=0x1FFF, mem_wdata=0xA5; ack=4'b0100 in cycle 4.
3. All four request at cycle 0, each dropping req after its own ack -> grant order 0,1,2,3; acks in cycles 4, 9, 14, 19; gnt_id steps 0->3.
4. Fairness: req0 re-asserted continuously, req3 held high -> ack sequence 0,3,0,3; req1 and req2 never acked.
5. rst_n pulled low in the WAIT cycle of a req0 read -> mem_en, ack and busy are 0 within the same cycle; no ack[0]. After release with req0 and req2 high, requester 0 is granted first.
6. MEM_LAT=1 build, single read -> mem_en in cycle 1, ack in cycle 3, service period 4 cycles.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the four-port memory arbiter.
package mem_arb_pkg;

  localparam int N_REQ  = 4;
  localparam int ADDR_W = 13;
  localparam int DATA_W = 8;
  localparam int ID_W   = 2;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} arb_state_t;

  typedef logic [ADDR_W-1:0] addr_t;
  typedef logic [DATA_W-1:0] data_t;

  function automatic logic [N_REQ-1:0] id_onehot(input logic [ID_W-1:0] id);
    logic [N_REQ-1:0] oh;
    oh     = '0;
    oh[id] = 1'b1;
    return oh;
  endfunction

endpackage

// File: rtl/rr_picker.sv
// Round-robin winner select: first set req bit after ptr, wrapping back to ptr.
// Latency: combinational.
// Backpressure: none; consumer decides when to take the winner.
module rr_picker
  import mem_arb_pkg::*;
(
  input  logic [N_REQ-1:0] req,
  input  logic [ID_W-1:0]  ptr,
  output logic             any_req,
  output logic [ID_W-1:0]  winner
);

  always_comb begin
    logic [ID_W-1:0] idx;
    logic            found;
    any_req = |req;
    winner  = ptr;
    found   = 1'b0;
    idx     = '0;
    // offset 4 wraps to ptr itself, so the last grantee has lowest priority
    for (int k = 1; k <= N_REQ; k++) begin
      idx = ptr + ID_W'(k);
      if (!found && req[idx]) begin
        winner = idx;
        found  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one fixed-latency single-port memory among four clients.
// Latency: request seen in IDLE -> mem_en next cycle -> ack MEM_LAT+2 cycles after the request.
// Backpressure: clients hold req until their one-cycle ack; inputs are only sampled in IDLE.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int MEM_LAT = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [N_REQ-1:0]        req,
  input  logic [N_REQ-1:0]        we,
  input  logic [N_REQ*ADDR_W-1:0] addr,
  input  logic [N_REQ*DATA_W-1:0] wdata,
  output logic [N_REQ-1:0]        ack,
  output logic [DATA_W-1:0]       rdata,
  output logic [ID_W-1:0]         gnt_id,
  output logic                    busy,
  output logic                    mem_en,
  output logic                    mem_we,
  output logic [ADDR_W-1:0]       mem_addr,
  output logic [DATA_W-1:0]       mem_wdata,
  input  logic [DATA_W-1:0]       mem_rdata
);

  arb_state_t      state;
  logic [ID_W-1:0] ptr;
  logic [2:0]      lat_cnt;
  logic            any_req;
  logic [ID_W-1:0] winner;

  rr_picker u_picker (
    .req     (req),
    .ptr     (ptr),
    .any_req (any_req),
    .winner  (winner)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      ptr       <= ID_W'(N_REQ-1);
      lat_cnt   <= '0;
      ack       <= '0;
      rdata     <= '0;
      gnt_id    <= '0;
      busy      <= 1'b0;
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (any_req) begin
            gnt_id    <= winner;
            mem_we    <= we[winner];
            mem_addr  <= addr[winner*ADDR_W +: ADDR_W];
            mem_wdata <= wdata[winner*DATA_W +: DATA_W];
            mem_en    <= 1'b1;
            busy      <= 1'b1;
            state     <= ISSUE;
          end
        end
        ISSUE: begin
          mem_en  <= 1'b0;
          lat_cnt <= 3'(MEM_LAT-1);
          state   <= WAIT;
        end
        WAIT: begin
          // data is captured for writes too; the client simply ignores it
          if (lat_cnt == '0) begin
            rdata <= mem_rdata;
            ack   <= id_onehot(gnt_id);
            state <= RESP;
          end else begin
            lat_cnt <= lat_cnt - 3'd1;
          end
        end
        RESP: begin
          ack   <= '0;
          ptr   <= gnt_id;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: MEM_LAT=2 instance plus a MEM_LAT=1 instance.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  req = '0, we = '0;
  logic [51:0] addr = '0;
  logic [31:0] wdata = '0;
  logic [3:0]  ack;
  logic [7:0]  rdata, mem_wdata, mem_rdata;
  logic [1:0]  gnt_id;
  logic        busy, mem_en, mem_we;
  logic [12:0] mem_addr;

  logic [3:0]  b_req = '0, b_we = '0;
  logic [51:0] b_addr = '0;
  logic [31:0] b_wdata = '0;
  logic [3:0]  b_ack;
  logic [7:0]  b_rdata, b_mem_wdata, b_mem_rdata;
  logic [1:0]  b_gnt_id;
  logic        b_busy, b_mem_en, b_mem_we;
  logic [12:0] b_mem_addr;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  mem_port_arbiter #(.MEM_LAT(2)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .we(we), .addr(addr), .wdata(wdata),
    .ack(ack), .rdata(rdata), .gnt_id(gnt_id), .busy(busy), .mem_en(mem_en),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  mem_port_arbiter #(.MEM_LAT(1)) dut_b (
    .clk(clk), .rst_n(rst_n), .req(b_req), .we(b_we), .addr(b_addr), .wdata(b_wdata),
    .ack(b_ack), .rdata(b_rdata), .gnt_id(b_gnt_id), .busy(b_busy), .mem_en(b_mem_en),
    .mem_we(b_mem_we), .mem_addr(b_mem_addr), .mem_wdata(b_mem_wdata), .mem_rdata(b_mem_rdata)
  );

  // Memory models: read value is addr[7:0]^0x99, visible only in the cycle MEM_LAT after mem_en.
  logic [1:0] p_v = '0;
  logic [7:0] p_d0 = '0, p_d1 = '0;
  logic       q_v = 1'b0;
  logic [7:0] q_d = '0;
  always @(posedge clk) begin
    p_v  <= {p_v[0], mem_en};
    p_d0 <= mem_addr[7:0] ^ 8'h99;
    p_d1 <= p_d0;
    q_v  <= b_mem_en;
    q_d  <= b_mem_addr[7:0] ^ 8'h99;
  end
  assign mem_rdata   = p_v[1] ? p_d1 : 8'hEE;
  assign b_mem_rdata = q_v ? q_d : 8'hEE;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req = '0; we = '0; b_req = '0; b_we = '0;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  function automatic int first_bit(input logic [3:0] v);
    for (int i = 0; i < 4; i++) if (v[i]) return i;
    return -1;
  endfunction

  int         ack_id  [8];
  int         ack_cyc [8];
  logic [7:0] ack_dat [8];
  int         n_ack;
  logic [3:0] ack_or;

  initial begin
    // ---- reset state ----
    do_reset();
    check("rst_ack", ack, 0);
    check("rst_rdata", rdata, 0);
    check("rst_gnt", gnt_id, 0);
    check("rst_busy", busy, 0);
    check("rst_mem_en", mem_en, 0);
    check("rst_mem_we", mem_we, 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_mem_wdata", mem_wdata, 0);

    // ---- 1: single read from requester 1 ----
    req = 4'b0010; we = 4'b0000; addr[13 +: 13] = 13'h0A5;
    tick();
    check("t1_c1_mem_en", mem_en, 1);
    check("t1_c1_mem_addr", mem_addr, 13'h0A5);
    check("t1_c1_mem_we", mem_we, 0);
    check("t1_c1_gnt", gnt_id, 1);
    check("t1_c1_busy", busy, 1);
    tick();
    check("t1_c2_mem_en", mem_en, 0);
    tick();
    check("t1_c3_ack", ack, 0);
    tick();
    check("t1_c4_ack", ack, 4'b0010);
    check("t1_c4_rdata", rdata, 8'h3C);
    req = '0;
    tick();
    check("t1_c5_busy", busy, 0);
    check("t1_c5_ack", ack, 0);
    check("t1_c5_rdata_hold", rdata, 8'h3C);
    check("t1_c5_gnt_hold", gnt_id, 1);
    check("t1_c5_addr_hold", mem_addr, 13'h0A5);

    // ---- 2: single write from requester 2 ----
    req = 4'b0100; we = 4'b0100; addr[26 +: 13] = 13'h1FFF; wdata[16 +: 8] = 8'hA5;
    tick();
    check("t2_c1_mem_en", mem_en, 1);
    check("t2_c1_mem_we", mem_we, 1);
    check("t2_c1_mem_addr", mem_addr, 13'h1FFF);
    check("t2_c1_mem_wdata", mem_wdata, 8'hA5);
    tick(); tick(); tick();
    check("t2_c4_ack", ack, 4'b0100);
    req = '0; we = '0;
    tick();

    // ---- 3: all four at once, round-robin 0,1,2,3 ----
    do_reset();
    addr = {13'h0333, 13'h1222, 13'h0111, 13'h0010};
    req = 4'b1111;
    n_ack = 0;
    for (int c = 1; c <= 22; c++) begin
      tick();
      if (c == 1) check("t3_gnt_c1", gnt_id, 0);
      if (c == 16) check("t3_gnt_c16", gnt_id, 3);
      if (ack != 0 && n_ack < 8) begin
        ack_id[n_ack]  = first_bit(ack);
        ack_cyc[n_ack] = c;
        ack_dat[n_ack] = rdata;
        n_ack++;
        req = req & ~ack;
      end
    end
    check("t3_n_ack", n_ack, 4);
    begin
      int         e_cyc [4] = '{4, 9, 14, 19};
      logic [7:0] e_dat [4] = '{8'h89, 8'h88, 8'hBB, 8'hAA};
      for (int i = 0; i < 4 && i < n_ack; i++) begin
        check($sformatf("t3_id%0d", i), ack_id[i], i);
        check($sformatf("t3_cyc%0d", i), ack_cyc[i], e_cyc[i]);
        check($sformatf("t3_dat%0d", i), ack_dat[i], e_dat[i]);
      end
    end
    req = '0;

    // ---- 4: fairness with req0 and req3 held ----
    do_reset();
    req = 4'b1001;
    n_ack = 0; ack_or = '0;
    for (int c = 1; c <= 20; c++) begin
      tick();
      ack_or = ack_or | ack;
      if (ack != 0 && n_ack < 8) begin
        ack_id[n_ack] = first_bit(ack);
        n_ack++;
      end
    end
    check("t4_n_ack", n_ack, 4);
    begin
      int e_id [4] = '{0, 3, 0, 3};
      for (int i = 0; i < 4 && i < n_ack; i++) check($sformatf("t4_id%0d", i), ack_id[i], e_id[i]);
    end
    check("t4_no_ack12", ack_or & 4'b0110, 0);
    req = '0;

    // ---- 5: reset asserted during WAIT ----
    do_reset();
    req = 4'b0001; addr[0 +: 13] = 13'h0005;
    tick();
    check("t5_c1_mem_en", mem_en, 1);
    tick();
    check("t5_c2_busy", busy, 1);
    #1 rst_n = 1'b0;
    #1;
    check("t5_rst_mem_en", mem_en, 0);
    check("t5_rst_busy", busy, 0);
    check("t5_rst_ack", ack, 0);
    check("t5_rst_addr", mem_addr, 0);
    ack_or = '0;
    for (int c = 0; c < 4; c++) begin
      tick();
      ack_or = ack_or | ack;
    end
    check("t5_no_ack_in_rst", ack_or, 0);
    req = 4'b0101; addr[26 +: 13] = 13'h0044;
    rst_n = 1'b1;
    tick();
    check("t5_post_gnt", gnt_id, 0);
    check("t5_post_mem_en", mem_en, 1);
    check("t5_post_addr", mem_addr, 13'h0005);
    req = '0;
    tick(); tick(); tick(); tick();

    // ---- 6: MEM_LAT=1 instance ----
    do_reset();
    b_req = 4'b0010; b_addr[13 +: 13] = 13'h0A5;
    tick();
    check("t6_c1_mem_en", b_mem_en, 1);
    tick();
    check("t6_c2_ack", b_ack, 0);
    tick();
    check("t6_c3_ack", b_ack, 4'b0010);
    check("t6_c3_rdata", b_rdata, 8'h3C);
    tick();
    check("t6_c4_busy", b_busy, 0);
    check("t6_c4_mem_en", b_mem_en, 0);
    tick();
    check("t6_c5_mem_en", b_mem_en, 1);
    tick(); tick();
    check("t6_c7_ack", b_ack, 4'b0010);
    b_req = '0;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
